// File: rtl/ising_seq_core.sv
// ising_seq_core: micro-instruction sequencer for the Ising machine.
// Executes a 16-bit instruction stream against NUM_VARS feedback FIFOs and
// an external beta stream. Each accepted instruction registers all FIFO
// heads onto the DAC channels, pops the selected FIFOs, and one cycle later
// pushes the selected ADC sample (MAC or NL) or zero into the chosen FIFOs.
// Per-cause sticky error flags are reported.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   run_trig, halt         start/resume; end-of-program on empty stream
//   instr_t*               instruction AXI-stream (sink)
//   beta_t*                beta AXI-stream (sink), consumed by pop-beta
//   var_in_*               CPU preload into FIFO i (any state)
//   var_out_*              CPU readback from FIFO i (blocked in RUN)
//   dac_data/dac_valid     channel i = var i, top channel = beta
//   mac_in, nl_in          ADC results
//   adc_run, run_done, halted, err_flags, state_out   status
//   del_*                  delay measurement, present only with
//                          ISING_SEQ_DEL_MEAS_EN defined
//
// Instruction: [3:0] pop var, [4] pop beta, [8:5] push ADC, [12:9] push 0,
// [13] toggle ADC source, [14] halt after this word, [15] ignored.

module ising_seq_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,   // head, 0 when empty
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  // A full FIFO drops the push even if a pop happens the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module ising_seq_core #(
  parameter int NUM_BITS   = 16,
  parameter int NUM_VARS   = 2,
  parameter int FIFO_DEPTH = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             run_trig,
  input  logic                             halt,
  input  logic [15:0]                      instr_tdata,
  input  logic                             instr_tvalid,
  output logic                             instr_tready,
  input  logic [NUM_BITS-1:0]              beta_tdata,
  input  logic                             beta_tvalid,
  output logic                             beta_tready,
  input  logic [NUM_VARS*NUM_BITS-1:0]     var_in_data,
  input  logic [NUM_VARS-1:0]              var_in_valid,
  output logic [NUM_VARS-1:0]              var_in_ready,
  output logic [NUM_VARS*NUM_BITS-1:0]     var_out_data,
  output logic [NUM_VARS-1:0]              var_out_valid,
  input  logic [NUM_VARS-1:0]              var_out_ready,
  output logic [(NUM_VARS+1)*NUM_BITS-1:0] dac_data,
  output logic [NUM_VARS:0]                dac_valid,
  input  logic [NUM_BITS-1:0]              mac_in,
  input  logic [NUM_BITS-1:0]              nl_in,
  output logic                             adc_run,
  output logic                             run_done,
  output logic                             halted,
  output logic [3:0]                       err_flags,
  output logic [2:0]                       state_out
`ifdef ISING_SEQ_DEL_MEAS_EN
  ,
  input  logic                             del_trig,
  input  logic [NUM_VARS:0]                del_chan_mask,
  input  logic [NUM_BITS-1:0]              del_val,
  input  logic [NUM_BITS-1:0]              del_thresh,
  output logic [15:0]                      del_mac_result,
  output logic [15:0]                      del_nl_result,
  output logic                             del_done
`endif
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_DONE = 3'd2;
  localparam logic [2:0] S_DEL  = 3'd3;

  logic [2:0] state_q, state_d;
  logic       accept, del_trig_w, err_clr;
  logic       src_q, push_src_q, adc_run_q, run_done_q, halted_q;
  logic [3:0] err_q, err_d;

  logic [NUM_VARS-1:0]                pop_bit, padc_bit, pzero_bit;
  logic [NUM_VARS-1:0]                push_adc_q, push_zero_q, fsm_push;
  logic [NUM_VARS-1:0]                fifo_push, fifo_pop, empty, full;
  logic [NUM_VARS-1:0][NUM_BITS-1:0]  head, fifo_wdata;
  logic [NUM_VARS:0][NUM_BITS-1:0]    dac_q, dac_d;
  logic [NUM_VARS:0]                  dac_vld_q, dac_vld_d;
  logic [NUM_BITS-1:0]                push_val;
  logic                               unused_instr;

  assign unused_instr = ^instr_tdata;   // bit 15 and out-of-range var bits

  // Reset is folded in so nothing is handshaken while the core is aborting.
  assign accept       = (state_q == S_RUN) & instr_tvalid & ~rst;
  assign instr_tready = (state_q == S_RUN) & ~rst;
  assign beta_tready  = accept & instr_tdata[4] & beta_tvalid;
  // ADC sample is taken in the push cycle, after the DAC has been driven.
  assign push_val     = push_src_q ? nl_in : mac_in;

`ifdef ISING_SEQ_DEL_MEAS_EN
  assign del_trig_w = del_trig;
`else
  assign del_trig_w = 1'b0;
`endif

  for (genvar i = 0; i < NUM_VARS; i++) begin : g_var
    assign pop_bit[i]   = instr_tdata[i];
    assign padc_bit[i]  = instr_tdata[5+i];
    assign pzero_bit[i] = instr_tdata[9+i];
    assign fsm_push[i]  = push_adc_q[i] | push_zero_q[i];
    // FSM push owns the write port; CPU is back-pressured that cycle.
    assign var_in_ready[i]  = ~full[i] & ~fsm_push[i];
    assign var_out_valid[i] = ~empty[i] & (state_q != S_RUN);
    assign var_out_data[i*NUM_BITS +: NUM_BITS] = head[i];
    assign fifo_push[i]  = fsm_push[i] | (var_in_valid[i] & var_in_ready[i]);
    assign fifo_pop[i]   = (accept & pop_bit[i]) | (var_out_valid[i] & var_out_ready[i]);
    assign fifo_wdata[i] = push_zero_q[i] ? '0 :
                           push_adc_q[i]  ? push_val :
                           var_in_data[i*NUM_BITS +: NUM_BITS];

    ising_seq_fifo #(.W(NUM_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push[i]),
      .wdata_i (fifo_wdata[i]),
      .pop_i   (fifo_pop[i]),
      .rdata_o (head[i]),
      .empty_o (empty[i]),
      .full_o  (full[i])
    );
  end

  for (genvar c = 0; c <= NUM_VARS; c++) begin : g_dac
    assign dac_data[c*NUM_BITS +: NUM_BITS] = dac_q[c];
  end
  assign dac_valid = dac_vld_q;

`ifdef ISING_SEQ_DEL_MEAS_EN
  logic [15:0] del_cnt_q, del_mac_q, del_nl_q;
  logic        mac_stop_q, nl_stop_q, del_done_q;
  logic        mac_x, nl_x, mac_hit, nl_hit, mac_to, nl_to, del_fin;

  function automatic logic [NUM_BITS:0] mag(input logic [NUM_BITS-1:0] x);
    logic [NUM_BITS:0] e;
    e = {x[NUM_BITS-1], x};
    return e[NUM_BITS] ? -e : e;
  endfunction

  assign mac_x   = mag(mac_in) > {1'b0, del_thresh};
  assign nl_x    = mag(nl_in)  > {1'b0, del_thresh};
  // A channel may still stop on the TIMEOUT-th cycle; past that it saturates.
  assign mac_hit = ~mac_stop_q & mac_x;
  assign nl_hit  = ~nl_stop_q & nl_x;
  assign mac_to  = ~mac_stop_q & ~mac_x & (del_cnt_q >= 16'(TIMEOUT));
  assign nl_to   = ~nl_stop_q & ~nl_x & (del_cnt_q >= 16'(TIMEOUT));
  assign del_fin = (state_q == S_DEL) & (mac_stop_q | mac_hit | mac_to)
                                      & (nl_stop_q | nl_hit | nl_to);

  always_ff @(posedge clk) begin
    if (rst) begin
      del_cnt_q  <= '0;
      del_mac_q  <= '0;
      del_nl_q   <= '0;
      mac_stop_q <= 1'b0;
      nl_stop_q  <= 1'b0;
      del_done_q <= 1'b0;
    end else if (state_q == S_IDLE && state_d == S_DEL) begin
      del_cnt_q  <= 16'd1;
      mac_stop_q <= 1'b0;
      nl_stop_q  <= 1'b0;
      del_done_q <= 1'b0;
    end else if (state_q == S_DEL) begin
      del_cnt_q <= del_cnt_q + 16'd1;
      if (mac_hit) del_mac_q <= del_cnt_q;
      if (mac_to)  del_mac_q <= 16'hFFFF;
      if (nl_hit)  del_nl_q  <= del_cnt_q;
      if (nl_to)   del_nl_q  <= 16'hFFFF;
      mac_stop_q <= mac_stop_q | mac_hit | mac_to;
      nl_stop_q  <= nl_stop_q | nl_hit | nl_to;
      if (del_fin) del_done_q <= 1'b1;
    end
  end

  assign del_mac_result = del_mac_q;
  assign del_nl_result  = del_nl_q;
  assign del_done       = del_done_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
`ifdef ISING_SEQ_DEL_MEAS_EN
        if (del_trig_w)    state_d = S_DEL;
        else
`endif
        if (run_trig)      state_d = S_RUN;
      end
      S_RUN: begin
        if (accept && instr_tdata[14])  state_d = S_IDLE;
        else if (!instr_tvalid && halt) state_d = S_DONE;
      end
      S_DONE:
        if (!run_trig && !halt && !del_trig_w) state_d = S_IDLE;
`ifdef ISING_SEQ_DEL_MEAS_EN
      S_DEL:
        if (del_fin) state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Errors clear only when a fresh program starts (previous one completed),
  // not when resuming after a halt instruction.
  assign err_clr = (state_q == S_IDLE) && (state_d == S_RUN) && run_done_q;

  always_comb begin
    err_d    = err_clr ? 4'd0 : err_q;
    err_d[0] = err_d[0] | (accept & |(pop_bit & empty));
    err_d[1] = err_d[1] | (accept & instr_tdata[4] & ~beta_tvalid);
    err_d[2] = err_d[2] | |(fsm_push & full);
    err_d[3] = err_d[3] | |(push_adc_q & push_zero_q);
  end

  always_comb begin
    dac_d     = dac_q;
    dac_vld_d = dac_vld_q;
    if (accept) begin
      for (int i = 0; i < NUM_VARS; i++) dac_d[i] = head[i];
      dac_d[NUM_VARS] = beta_tvalid ? beta_tdata : '0;
      dac_vld_d       = '1;
    end
`ifdef ISING_SEQ_DEL_MEAS_EN
    if (state_q == S_IDLE && state_d == S_DEL) begin
      for (int c = 0; c <= NUM_VARS; c++) dac_d[c] = del_chan_mask[c] ? del_val : '0;
      dac_vld_d = '1;
    end else if (state_q == S_DEL) begin
      dac_d = '0;   // stimulus is a single-cycle pulse
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      src_q       <= 1'b0;
      push_src_q  <= 1'b0;
      push_adc_q  <= '0;
      push_zero_q <= '0;
      dac_q       <= '0;
      dac_vld_q   <= '0;
      err_q       <= '0;
      adc_run_q   <= 1'b0;
      run_done_q  <= 1'b1;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_q ^ (accept & instr_tdata[13]);
      push_src_q  <= src_q;   // source before this word's toggle
      push_adc_q  <= accept ? padc_bit  : '0;
      push_zero_q <= accept ? pzero_bit : '0;
      dac_q       <= dac_d;
      dac_vld_q   <= dac_vld_d;
      err_q       <= err_d;
      adc_run_q   <= (state_d == S_RUN);
      // halted: set on any entry to IDLE, held while idle (not after reset).
      halted_q    <= (state_d == S_IDLE) && ((state_q != S_IDLE) || halted_q);
      if (state_d == S_DONE)                          run_done_q <= 1'b1;
      else if (state_q == S_IDLE && state_d != S_IDLE) run_done_q <= 1'b0;
    end
  end

  assign adc_run   = adc_run_q;
  assign run_done  = run_done_q;
  assign halted    = halted_q;
  assign err_flags = err_q;
  assign state_out = state_q;
endmodule
